lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store initiator between the single-cycle CPU datapath and the data memory port. Accepts one load or store per handshake and issues a word-aligned request with byte strobes on a valid/ready memory channel. Waits for the memory response (with a timeout), then returns lane-shifted, sign- or zero-extended read data to the CPU as a one-cycle response pulse. Misaligned accesses and illegal operations are rejected without touching memory.

## Interface
- TIMEOUT, 256, maximum cycles spent in WAIT before an error response; legal range 1..65535
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_op  in  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; others illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, illegal op or timeout
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write
- mem_addr  out  32  {req_addr[31:2], 2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables; 4'b0000 for loads
- mem_resp_valid  in  1  memory read data or write ack
- mem_rdata  in  32  memory read word

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1 (0 while rst is high). On req_valid: capture we, op, addr[1:0], wdata, aligned address.
  - Illegal op (011, 110, 111), half with addr[0] = 1, or word with addr[1:0] != 0 -> RESP with err = 1.
  - Otherwise -> REQ.
- REQ: mem_req_valid = 1. Address, we, wdata and wstrb stay stable until mem_req_ready. On ready -> WAIT, with the timeout counter cleared.
- WAIT: the counter increments each cycle.
  - mem_resp_valid -> RESP with err = 0. The read word is latched and processed.
  - Counter reaches TIMEOUT - 1 without a response -> RESP with err = 1 and rdata = 0.
- RESP: resp_valid = 1 for exactly one cycle -> IDLE. No CPU backpressure.
- Store lanes (op[1:0] selects size; op[2] ignored for stores):
  - byte: wdata {4{wd[7:0]}}, wstrb 4'b0001 << addr[1:0].
  - half: wdata {2{wd[15:0]}}, wstrb 4'b0011 << addr[1:0].
  - word: wdata wd, wstrb 4'b1111.
- Load data: s = mem_rdata >> (8*addr[1:0]).
  - op 000: sign-extend s[7:0]. op 100: zero-extend s[7:0].
  - op 001: sign-extend s[15:0]. op 101: zero-extend s[15:0].
  - op 010: s.
- mem_resp_valid outside WAIT is ignored. The memory contract forbids responses after a timeout.
- Reset mid-operation: next state IDLE, mem_req_valid drops immediately, the pending transaction is abandoned, no resp_valid.

## Timing
- Reset values: state IDLE, resp_valid 0, resp_err 0, resp_rdata 0, mem_req_valid 0, mem_we 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, counter 0.
- All outputs except req_ready are registered. req_ready = (state == IDLE) & ~rst.
- Best case: accept at cycle N, mem_req_valid at N+1 with mem_req_ready = 1, mem_resp_valid at N+2, resp_valid at N+3.
- Error path: accept at N, resp_valid at N+1. mem_req_valid never asserts.
- Memory must not return mem_resp_valid in the same cycle as the request handshake. A response in that cycle is ignored.
- Next request is accepted the cycle after resp_valid, giving a throughput of at most one transaction per 4 cycles.

## Test plan
- Load byte signed, addr 0x80000003, mem_rdata 0x80FF1234 -> mem_addr 0x80000000, mem_wstrb 0000, resp_rdata 0xFFFFFF80, err 0, resp_valid at accept+3.
- Load half unsigned, addr 0x80000002, mem_rdata 0xBEEF0000 -> resp_rdata 0x0000BEEF. The same load with op 001 -> 0xFFFFBEEF.
- Store byte, addr 0x80000001, wdata 0x000000AB, mem_req_ready held low 3 cycles -> mem_req_valid held 4 cycles with stable mem_wdata 0xABABABAB and wstrb 0010. After the ack, resp_valid with rdata 0.
- Word load at 0x80000002, half at 0x80000001, and op 011 -> resp_valid at accept+1, err 1, mem_req_valid never high.
- TIMEOUT = 4, memory never responds -> resp_valid with err 1 exactly 4 cycles after entering WAIT. A stray mem_resp_valid in IDLE produces no response.
- rst asserted during REQ and during WAIT -> mem_req_valid 0 and req_ready 0 in the reset cycle, IDLE afterward, no resp_valid. The next request completes normally.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundles the CPU-side load/store channel and the memory-side
// valid/ready channel of the load/store unit.
//   CPU side   : req_valid/req_ready/req_we/req_op/req_addr/req_wdata,
//                resp_valid/resp_rdata/resp_err
//   Memory side: mem_req_valid/mem_req_ready/mem_we/mem_addr/mem_wdata/
//                mem_wstrb, mem_resp_valid/mem_rdata
// Modports:
//   master - the load/store controller (accepts CPU requests, initiates memory)
//   slave  - the environment around it (CPU datapath plus data memory)
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store initiator between the CPU datapath and the data memory.
// Accepts one load/store per CPU handshake, issues a word-aligned request with
// byte strobes, waits (bounded by TIMEOUT cycles) for the memory response and
// returns extended read data as a one-cycle resp_valid pulse. Misaligned
// accesses and illegal ops are answered with resp_err without a memory access.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_ctrl_if.master: CPU request/response and memory channel
// Parameter:
//   TIMEOUT - maximum cycles spent waiting for a memory response (1..65535)
module lsu_ctrl #(
  parameter int TIMEOUT = 256
) (
  input logic        clk,
  input logic        rst,
  lsu_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  op_reg;
  logic [1:0]  lo_reg;
  logic [15:0] cnt_reg;

  logic        mem_req_valid_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;
  logic        resp_valid_reg;
  logic        resp_err_reg;
  logic [31:0] resp_rdata_reg;

  logic        accept;
  logic        bad_req;
  logic        timeout_hit;
  logic [31:0] lane_b;
  logic [31:0] lane_h;
  logic [31:0] store_data;
  logic [3:0]  store_strb;
  logic [31:0] load_shift;
  logic [31:0] load_ext;

  assign accept      = (state_reg == IDLE) && bus.req_valid;
  assign timeout_hit = (cnt_reg == CNT_LAST);

  // Byte and halfword replication across all four lanes, so the strobe alone
  // decides which lane memory actually writes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_b[8*gi +: 8] = bus.req_wdata[7:0];
    assign lane_h[8*gi +: 8] = bus.req_wdata[8*(gi%2) +: 8];
  end

  // Reject illegal encodings and accesses not aligned to their own size.
  always_comb begin
    bad_req = 1'b0;
    case (bus.req_op)
      3'b011, 3'b110, 3'b111: bad_req = 1'b1;
      3'b001, 3'b101:         bad_req = bus.req_addr[0];
      3'b010:                 bad_req = |bus.req_addr[1:0];
      default:                bad_req = 1'b0;
    endcase
  end

  // Store size comes from op[1:0]; the signedness bit has no meaning here.
  always_comb begin
    store_data = bus.req_wdata;
    store_strb = 4'b1111;
    case (bus.req_op[1:0])
      2'b00: begin
        store_data = lane_b;
        store_strb = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        store_data = lane_h;
        store_strb = 4'b0011 << bus.req_addr[1:0];
      end
      default: begin
        store_data = bus.req_wdata;
        store_strb = 4'b1111;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by op.
  always_comb begin
    load_shift = bus.mem_rdata >> {lo_reg, 3'b000};
    load_ext   = load_shift;
    case (op_reg)
      3'b000:  load_ext = {{24{load_shift[7]}}, load_shift[7:0]};
      3'b100:  load_ext = {24'd0, load_shift[7:0]};
      3'b001:  load_ext = {{16{load_shift[15]}}, load_shift[15:0]};
      3'b101:  load_ext = {16'd0, load_shift[15:0]};
      default: load_ext = load_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          state_next = bad_req ? RESP : REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_resp_valid || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output registers are loaded from the next state so that every output
  // except req_ready comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg            <= 1'b0;
      op_reg            <= 3'd0;
      lo_reg            <= 2'd0;
      cnt_reg           <= 16'd0;
      mem_req_valid_reg <= 1'b0;
      mem_we_reg        <= 1'b0;
      mem_addr_reg      <= 32'd0;
      mem_wdata_reg     <= 32'd0;
      mem_wstrb_reg     <= 4'd0;
      resp_valid_reg    <= 1'b0;
      resp_err_reg      <= 1'b0;
      resp_rdata_reg    <= 32'd0;
    end else begin
      mem_req_valid_reg <= (state_next == REQ);
      resp_valid_reg    <= (state_next == RESP);
      resp_err_reg      <= 1'b0;
      resp_rdata_reg    <= 32'd0;

      if (accept) begin
        we_reg <= bus.req_we;
        op_reg <= bus.req_op;
        lo_reg <= bus.req_addr[1:0];
        if (bad_req) begin
          resp_err_reg <= 1'b1;
        end else begin
          mem_addr_reg  <= {bus.req_addr[31:2], 2'b00};
          mem_we_reg    <= bus.req_we;
          mem_wdata_reg <= store_data;
          mem_wstrb_reg <= bus.req_we ? store_strb : 4'b0000;
        end
      end

      if (state_reg == REQ) begin
        cnt_reg <= 16'd0;
      end

      if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg + 16'd1;
        if (bus.mem_resp_valid) begin
          resp_rdata_reg <= we_reg ? 32'd0 : load_ext;
        end else if (timeout_hit) begin
          resp_err_reg <= 1'b1;
        end
      end
    end
  end

  // Masking with rst withdraws a pending memory request in the very cycle
  // reset is applied, so memory can never complete a handshake under reset.
  assign bus.req_ready     = (state_reg == IDLE) && !rst;
  assign bus.mem_req_valid = mem_req_valid_reg && !rst;
  assign bus.mem_we        = mem_we_reg;
  assign bus.mem_addr      = mem_addr_reg;
  assign bus.mem_wdata     = mem_wdata_reg;
  assign bus.mem_wstrb     = mem_wstrb_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_err      = resp_err_reg;
  assign bus.resp_rdata    = resp_rdata_reg;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl. Drives directed and random
// load/store transactions through a small memory responder and compares the
// observed memory request and CPU response against a reference model built
// from sizes, lanes and cycle arithmetic.
module tb_lsu_ctrl;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          nvalid;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mstrb;
    logic        mwe;
    logic        stable;
    logic        ready0;
    logic        resp_at_acc;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int op_size(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic m_bad(input logic [2:0] op, input logic [31:0] a);
    int lo = int'(a[1:0]);
    if (op == 3'd3 || op == 3'd6 || op == 3'd7) return 1'b1;
    return (lo % op_size(op)) != 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] word);
    int sz = op_size(op);
    logic [31:0] v;
    logic [31:0] mask;
    v = word >> (8 * int'(a[1:0]));
    if (sz == 4) return v;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = v & mask;
    if (!op[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] wd);
    int sz = op_size(op);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = wd[8*(b % sz) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] op, input logic [31:0] a);
    int sz = op_size(op);
    int lo = int'(a[1:0]);
    logic [3:0] s;
    for (int b = 0; b < 4; b++) s[b] = (b >= lo) && (b < lo + sz);
    return s;
  endfunction

  function automatic int m_lat(input logic bad, input int rdy, input int rsp);
    if (bad) return 1;
    if (rsp < TMO) return rdy + 3 + rsp;
    return rdy + 2 + TMO;
  endfunction

  // ---------------- driver / memory responder ----------------
  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword,
                         input int rdy_dly, input int rsp_dly, input logic stray,
                         output obs_t o);
    int acc;
    int hs;
    bit done;
    o = '{default: 0};
    o.lat = -1;
    o.stable = 1'b1;
    hs = -1;
    done = 0;
    @(negedge clk);
    o.ready0 = bus.req_ready;
    o.resp_at_acc = bus.resp_valid;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    acc = cyc;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      bus.req_valid      = 1'b0;
      bus.req_we         = 1'($urandom);
      bus.req_op         = 3'($urandom);
      bus.req_addr       = $urandom;
      bus.req_wdata      = $urandom;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_rdata      = $urandom;
      if (bus.resp_valid) begin
        o.lat   = cyc - acc;
        o.rdata = bus.resp_rdata;
        o.err   = bus.resp_err;
        done    = 1;
      end else if (bus.mem_req_valid) begin
        if (o.nvalid == 0) begin
          o.maddr  = bus.mem_addr;
          o.mwdata = bus.mem_wdata;
          o.mstrb  = bus.mem_wstrb;
          o.mwe    = bus.mem_we;
        end else if (o.maddr !== bus.mem_addr || o.mwdata !== bus.mem_wdata ||
                     o.mstrb !== bus.mem_wstrb || o.mwe !== bus.mem_we) begin
          o.stable = 1'b0;
        end
        if (o.nvalid == rdy_dly) begin
          bus.mem_req_ready = 1'b1;
          hs = cyc;
          if (stray) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = ~rword;
          end
        end
        o.nvalid++;
      end else if (hs >= 0 && rsp_dly < TMO && cyc == hs + 1 + rsp_dly) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rword;
      end
    end
    $display("txn we=%0d op=%0d addr=%08h wdata=%08h lat=%0d rdata=%08h err=%0d reqs=%0d",
             we, op, addr, wd, o.lat, o.rdata, o.err, o.nvalid);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%0d exp=0", bus.req_ready); end
    checks++; if (bus.mem_req_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
      errors++; $display("FAIL reset_valids mrv=%0d rv=%0d re=%0d exp=0", bus.mem_req_valid, bus.resp_valid, bus.resp_err); end
    checks++; if (bus.resp_rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0 ||
                  bus.mem_wstrb !== 4'd0 || bus.mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_data rdata=%08h addr=%08h wdata=%08h strb=%h we=%0d exp=0",
                         bus.resp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, bus.mem_we); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%0d exp=1", bus.req_ready); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 1'b0, o);
    checks++; if (o.ready0 !== 1'b1) begin errors++; $display("FAIL lb_ready got=%0d exp=1", o.ready0); end
    checks++; if (o.maddr !== 32'h8000_0000) begin errors++; $display("FAIL lb_addr got=%08h exp=80000000", o.maddr); end
    checks++; if (o.mstrb !== 4'b0000 || o.mwe !== 1'b0) begin errors++; $display("FAIL lb_strb got=%b/%0d exp=0000/0", o.mstrb, o.mwe); end
    checks++; if (o.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rdata got=%08h exp=ffffff80", o.rdata); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL lb_err got=%0d exp=0", o.err); end
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL lb_latency got=%0d exp=3", o.lat); end
  endtask

  task automatic test_load_half();
    obs_t o;
    run_txn(1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 1, 1'b0, o);
    checks++; if (o.rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_rdata got=%08h exp=0000beef", o.rdata); end
    run_txn(1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hBEEF_0000, 0, 1, 1'b0, o);
    checks++; if (o.rdata !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_rdata got=%08h exp=ffffbeef", o.rdata); end
    checks++; if (o.resp_at_acc !== 1'b0) begin errors++; $display("FAIL resp_pulse_width got=%0d exp=0", o.resp_at_acc); end
  endtask

  task automatic test_store_backpressure();
    obs_t o;
    run_txn(1'b1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h1234_5678, 3, 0, 1'b0, o);
    checks++; if (o.nvalid !== 4) begin errors++; $display("FAIL sb_valid_cycles got=%0d exp=4", o.nvalid); end
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL sb_stable got=%0d exp=1", o.stable); end
    checks++; if (o.mwdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got=%08h exp=abababab", o.mwdata); end
    checks++; if (o.mstrb !== 4'b0010 || o.mwe !== 1'b1) begin errors++; $display("FAIL sb_strb got=%b/%0d exp=0010/1", o.mstrb, o.mwe); end
    checks++; if (o.rdata !== 32'd0 || o.err !== 1'b0) begin errors++; $display("FAIL sb_resp got=%08h/%0d exp=0/0", o.rdata, o.err); end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [2:0]  ops [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] ads [3] = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, ops[i], ads[i], 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, o);
      checks++; if (o.lat !== 1 || o.err !== 1'b1) begin errors++; $display("FAIL err_resp[%0d] lat=%0d err=%0d exp=1/1", i, o.lat, o.err); end
      checks++; if (o.nvalid !== 0 || o.rdata !== 32'd0) begin errors++; $display("FAIL err_nomem[%0d] reqs=%0d rdata=%08h exp=0/0", i, o.nvalid, o.rdata); end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 3'b010, 32'h8000_0010, 32'h0, 32'h1111_2222, 0, 99, 1'b0, o);
    checks++; if (o.lat !== 2 + TMO) begin errors++; $display("FAIL tmo_latency got=%0d exp=%0d", o.lat, 2 + TMO); end
    checks++; if (o.err !== 1'b1 || o.rdata !== 32'd0) begin errors++; $display("FAIL tmo_resp got=%0d/%08h exp=1/0", o.err, o.rdata); end
    // Stray memory response while idle must not create a CPU response.
    @(negedge clk);
    bus.mem_resp_valid = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL idle_stray[%0d] got=%0d exp=0", i, bus.resp_valid); end
    end
  endtask

  task automatic test_reset_mid(input bit in_wait);
    obs_t o;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_op = 3'b010;
    bus.req_addr = 32'h8000_0040; bus.req_wdata = 32'h0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL rm_req_up[%0d] got=%0d exp=1", in_wait, bus.mem_req_valid); end
    if (in_wait) begin
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
    end
    rst = 1'b1;
    bus.mem_resp_valid = in_wait;
    #1;
    checks++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      errors++; $display("FAIL rm_in_reset[%0d] mrv=%0d rdy=%0d exp=0/0", in_wait, bus.mem_req_valid, bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.mem_resp_valid = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rm_idle[%0d] got=%0d exp=1", in_wait, bus.req_ready); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
        errors++; $display("FAIL rm_quiet[%0d.%0d] rv=%0d mrv=%0d exp=0/0", in_wait, i, bus.resp_valid, bus.mem_req_valid); end
    end
    run_txn(1'b0, 3'b100, 32'h8000_0041, 32'h0, 32'h0000_9A00, 1, 0, 1'b0, o);
    checks++; if (o.rdata !== 32'h0000_009A || o.err !== 1'b0 || o.lat !== 4) begin
      errors++; $display("FAIL rm_after[%0d] rdata=%08h err=%0d lat=%0d exp=0000009a/0/4", in_wait, o.rdata, o.err, o.lat); end
  endtask

  task automatic test_random();
    obs_t o;
    for (int n = 0; n < 40; n++) begin
      logic        we    = 1'($urandom);
      logic [2:0]  op    = 3'($urandom);
      logic [31:0] addr  = $urandom;
      logic [31:0] wd    = $urandom;
      logic [31:0] rword = $urandom;
      int          rdy   = int'($urandom_range(0, 3));
      int          rsp   = int'($urandom_range(0, 6));
      logic        stray = 1'($urandom);
      logic        bad   = m_bad(op, addr);
      logic        tmo   = !bad && rsp >= TMO;
      logic [31:0] er    = (bad || tmo || we) ? 32'd0 : m_load(op, addr, rword);
      run_txn(we, op, addr, wd, rword, rdy, rsp, stray, o);
      checks++; if (o.lat !== m_lat(bad, rdy, rsp)) begin errors++; $display("FAIL rnd_lat[%0d] got=%0d exp=%0d", n, o.lat, m_lat(bad, rdy, rsp)); end
      checks++; if (o.err !== (bad || tmo)) begin errors++; $display("FAIL rnd_err[%0d] got=%0d exp=%0d", n, o.err, bad || tmo); end
      checks++; if (o.rdata !== er) begin errors++; $display("FAIL rnd_rdata[%0d] got=%08h exp=%08h", n, o.rdata, er); end
      checks++; if (o.nvalid !== (bad ? 0 : rdy + 1)) begin errors++; $display("FAIL rnd_reqs[%0d] got=%0d exp=%0d", n, o.nvalid, bad ? 0 : rdy + 1); end
      if (!bad) begin
        checks++; if (o.maddr !== {addr[31:2], 2'b00} || o.mwe !== we || o.stable !== 1'b1) begin
          errors++; $display("FAIL rnd_req[%0d] addr=%08h we=%0d stable=%0d exp=%08h/%0d/1", n, o.maddr, o.mwe, o.stable, {addr[31:2], 2'b00}, we); end
        checks++; if (o.mstrb !== (we ? m_strb(op, addr) : 4'b0000)) begin
          errors++; $display("FAIL rnd_strb[%0d] got=%b exp=%b", n, o.mstrb, we ? m_strb(op, addr) : 4'b0000); end
        if (we) begin
          checks++; if (o.mwdata !== m_wdata(op, wd)) begin errors++; $display("FAIL rnd_wdata[%0d] got=%08h exp=%08h", n, o.mwdata, m_wdata(op, wd)); end
        end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = 32'd0;
    test_reset();
    test_load_byte();
    test_load_half();
    test_store_backpressure();
    test_errors();
    test_timeout();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
